seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan stage with dead-time blanking and frame-aligned word updates.
// Optional LEADING_BLANK_EN: leading zeros on digits 3..1 are stored as spaces when a word commits.
module seg_scan_driver #(
  parameter int REFRESH_CYCLES = 250000,
  parameter int DEAD_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_chars,
  output logic        load_ready,
  output logic [3:0]  char,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [3:0]    SPACE    = 4'd12;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    char_q, char_d;
  logic          tick_q, tick_d;
  logic          cnt_wrap, frame_end, xfer;

  function automatic logic [15:0] commit_word(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef LEADING_BLANK_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int d = 3; d >= 1; d--) begin
        zero_run = zero_run && (w[4*d +: 4] == 4'd0);
        if (zero_run) r[4*d +: 4] = SPACE;
      end
    end
`else
`endif
    return r;
  endfunction

  always_comb begin
    cnt_wrap    = (cnt_q == CNT_MAX);
    frame_end   = cnt_wrap && (idx_q == 2'd3);
    xfer        = load_valid && !pend_full_q;
    cnt_d       = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d       = cnt_wrap ? idx_q + 2'd1 : idx_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    wrap_d      = frame_end;
    // wrap_q delays the pulse so it lands on the first dead cycle of digit 0
    tick_d      = wrap_q;

    // commit and transfer are mutually exclusive: transfer needs pending empty
    if (frame_end && pend_full_q) begin
      active_d    = commit_word(pend_q);
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_d      = load_chars;
      pend_full_d = 1'b1;
    end

    if (cnt_q < CNT_DEAD) begin
      anode_d = 4'b1111;
      char_d  = SPACE;
    end else begin
      anode_d = ~(4'b0001 << idx_q);
      char_d  = active_q[{idx_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      active_q    <= 16'hCCCC;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
      wrap_q      <= 1'b0;
      anode_q     <= 4'b1111;
      char_q      <= SPACE;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      wrap_q      <= wrap_d;
      anode_q     <= anode_d;
      char_q      <= char_d;
      tick_q      <= tick_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign anode      = anode_q;
  assign char       = char_q;
  assign frame_tick = tick_q;

endmodule
